ctrl_pipe_unit: RTL and testbench



---
 rtl/rv_ctrl_pkg.sv | 66 ++++++
 rtl/rv_ctrl_decode.sv | 154 +++++++++++++++
 rtl/ctrl_pipe_unit.sv | 120 ++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the RV32 pipelined control unit.
// Contents: opcode constants, ALUOp / SrcASel / MemtoReg encodings, and the
// packed control word that travels from the decoder into the ID/EX register.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    // The rd field is always carried at full RV32I width; narrower register
    // files slice it at the point of use.
    localparam int RD_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_BRANCH = 3'b001,
        ALU_R      = 3'b010,
        ALU_I      = 3'b011,
        ALU_U      = 3'b100,
        ALU_MEXT   = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_ZERO = 2'b01,
        SRC_A_PC   = 2'b11
    } src_a_sel_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MEM = 2'b01,
        M2R_PC4 = 2'b11
    } mem_to_reg_e;

    typedef struct packed {
        logic              branch;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic              reg_write;
        alu_op_e           alu_op;
        src_a_sel_e        src_a_sel;
        mem_to_reg_e       mem_to_reg;
        logic [RD_W-1:0]   rd;
        logic              illegal;
        logic              is_div;
        logic              uses_rs1;
        logic              uses_rs2;
    } ctrl_word_t;

    // DIV/DIVU/REM/REMU all have funct3[2] set within the M-extension group.
    function automatic logic is_div_funct3(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32 main control decoder.
// Ports:
//   instr - 32-bit instruction word held in ID
//   ctrl  - full control word, including register-use flags and divide marker
// Illegal encodings (unknown opcode, M-ext with ENABLE_M=0, or register
// fields beyond an RV32E file) produce an all-zero word with illegal=1.
import rv_ctrl_pkg::*;

module rv_ctrl_decode #(
    parameter int REG_ADDR_W = 5,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl
);

    localparam bit RVE = (REG_ADDR_W < 5);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    ctrl_word_t cw_s;
    logic       has_rd_s;
    logic       bad_s;
    logic       unused_instr_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    // Immediate bits carry no control information.
    assign unused_instr_s = ^instr;

    // Opcode decode followed by rd=0 and legality post-processing.
    always_comb begin
        cw_s     = '0;
        has_rd_s = 1'b0;
        bad_s    = 1'b0;
        case (opcode_s)
            OPC_BRANCH: begin
                cw_s.branch   = 1'b1;
                cw_s.alu_op   = ALU_BRANCH;
                cw_s.uses_rs1 = 1'b1;
                cw_s.uses_rs2 = 1'b1;
            end
            OPC_STORE: begin
                cw_s.alu_src   = 1'b1;
                cw_s.mem_write = 1'b1;
                cw_s.alu_op    = ALU_ADD;
                cw_s.uses_rs1  = 1'b1;
                cw_s.uses_rs2  = 1'b1;
            end
            OPC_OP: begin
                cw_s.reg_write = 1'b1;
                cw_s.uses_rs1  = 1'b1;
                cw_s.uses_rs2  = 1'b1;
                has_rd_s       = 1'b1;
                if (funct7_s == FUNCT7_MEXT) begin
                    if (ENABLE_M) begin
                        cw_s.alu_op = ALU_MEXT;
                        cw_s.is_div = is_div_funct3(funct3_s);
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    cw_s.alu_op = ALU_R;
                end
            end
            OPC_LOAD: begin
                cw_s.alu_src    = 1'b1;
                cw_s.reg_write  = 1'b1;
                cw_s.mem_read   = 1'b1;
                cw_s.mem_to_reg = M2R_MEM;
                cw_s.alu_op     = ALU_ADD;
                cw_s.uses_rs1   = 1'b1;
                has_rd_s        = 1'b1;
            end
            OPC_OP_IMM, OPC_SYSTEM: begin
                cw_s.alu_src   = 1'b1;
                cw_s.reg_write = 1'b1;
                cw_s.alu_op    = ALU_I;
                cw_s.uses_rs1  = 1'b1;
                has_rd_s       = 1'b1;
            end
            OPC_FENCE: begin
                cw_s = '0;
            end
            OPC_JALR: begin
                cw_s.alu_src    = 1'b1;
                cw_s.reg_write  = 1'b1;
                cw_s.alu_op     = ALU_I;
                cw_s.mem_to_reg = M2R_PC4;
                cw_s.uses_rs1   = 1'b1;
                has_rd_s        = 1'b1;
            end
            OPC_AUIPC: begin
                cw_s.alu_src   = 1'b1;
                cw_s.reg_write = 1'b1;
                cw_s.src_a_sel = SRC_A_PC;
                cw_s.alu_op    = ALU_U;
                has_rd_s       = 1'b1;
            end
            OPC_LUI: begin
                cw_s.alu_src   = 1'b1;
                cw_s.reg_write = 1'b1;
                cw_s.src_a_sel = SRC_A_ZERO;
                cw_s.alu_op    = ALU_U;
                has_rd_s       = 1'b1;
            end
            OPC_JAL: begin
                cw_s.alu_src    = 1'b1;
                cw_s.reg_write  = 1'b1;
                cw_s.src_a_sel  = SRC_A_ZERO;
                cw_s.mem_to_reg = M2R_PC4;
                cw_s.alu_op     = ALU_ADD;
                has_rd_s        = 1'b1;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase

        // Formats without a destination carry rd=0 so it never matches a hazard.
        if (has_rd_s) begin
            cw_s.rd = instr[11:7];
        end else begin
            cw_s.rd = 5'd0;
        end

        // Writes to x0 are architectural no-ops.
        if (cw_s.rd == 5'd0) begin
            cw_s.reg_write = 1'b0;
        end else begin
            cw_s.reg_write = cw_s.reg_write;
        end

        // RV32E only has x0..x15: any used register field with bit 4 set is illegal.
        if (RVE && ((has_rd_s && instr[11]) || (cw_s.uses_rs1 && instr[19]) ||
                    (cw_s.uses_rs2 && instr[24]))) begin
            bad_s = 1'b1;
        end else begin
            bad_s = bad_s;
        end

        if (bad_s) begin
            cw_s         = '0;
            cw_s.illegal = 1'b1;
        end else begin
            cw_s.illegal = 1'b0;
        end
    end

    assign ctrl = cw_s;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Pipelined RV32 control unit: decodes the ID instruction and holds the
// resulting control word in an ID/EX register with valid/ready handshakes.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   id_valid/id_instr - instruction offered by ID; id_ready accepts it
//   ex_flush          - taken branch/jump, kills the ID/EX entry
//   ex_ready/ex_valid - EX-side handshake
//   ex_*              - registered control bits of the held instruction
//   ex_mdu_busy       - a divide is still occupying EX
// Load-use hazards stall ID for one bubble; divides hold EX for MDU_LAT cycles.
import rv_ctrl_pkg::*;

module ctrl_pipe_unit #(
    parameter int REG_ADDR_W = 5,
    parameter bit ENABLE_M   = 1'b1,
    parameter int MDU_LAT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    output logic                  id_ready,
    input  logic                  ex_flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic [2:0]            ex_alu_op,
    output logic [1:0]            ex_src_a_sel,
    output logic [1:0]            ex_mem_to_reg,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_illegal,
    output logic                  ex_mdu_busy
);

    localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(MDU_LAT - 1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

    ctrl_word_t            dec_s;
    ctrl_word_t            ctrl_r;
    logic                  occ_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [REG_ADDR_W-1:0] rs1_s;
    logic [REG_ADDR_W-1:0] rs2_s;
    logic [REG_ADDR_W-1:0] held_rd_s;
    logic                  can_load_s;
    logic                  hazard_s;
    logic                  capture_s;
    logic                  unused_ctrl_s;

    rv_ctrl_decode #(
        .REG_ADDR_W (REG_ADDR_W),
        .ENABLE_M   (ENABLE_M)
    ) u_decode (
        .instr (id_instr),
        .ctrl  (dec_s)
    );

    assign rs1_s     = id_instr[15 +: REG_ADDR_W];
    assign rs2_s     = id_instr[20 +: REG_ADDR_W];
    assign held_rd_s = ctrl_r.rd[REG_ADDR_W-1:0];

    assign ex_valid    = occ_r & (cnt_r == CNT_ZERO);
    assign ex_mdu_busy = occ_r & (cnt_r != CNT_ZERO);

    // The slot frees up either because it is empty or because it drains now.
    assign can_load_s = ~occ_r | (ex_valid & ex_ready);

    // A held load feeding a register that the ID instruction reads.
    assign hazard_s = occ_r & ctrl_r.mem_read & (held_rd_s != REG_ZERO) &
                      ((dec_s.uses_rs1 & (rs1_s == held_rd_s)) |
                       (dec_s.uses_rs2 & (rs2_s == held_rd_s)));

    assign id_ready  = ~rst & ~ex_flush & can_load_s & ~hazard_s;
    assign capture_s = id_valid & id_ready;

    // ID/EX register, occupancy bit and divide countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r <= '0;
            occ_r  <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else if (ex_flush) begin
            ctrl_r <= '0;
            occ_r  <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else if (capture_s) begin
            ctrl_r <= dec_s;
            occ_r  <= 1'b1;
            cnt_r  <= dec_s.is_div ? CNT_DIV : CNT_ZERO;
        end else if (ex_valid & ex_ready) begin
            occ_r <= 1'b0;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            occ_r <= occ_r;
        end
    end

    assign ex_branch     = ctrl_r.branch;
    assign ex_mem_read   = ctrl_r.mem_read;
    assign ex_mem_write  = ctrl_r.mem_write;
    assign ex_alu_src    = ctrl_r.alu_src;
    assign ex_reg_write  = ctrl_r.reg_write;
    assign ex_alu_op     = ctrl_r.alu_op;
    assign ex_src_a_sel  = ctrl_r.src_a_sel;
    assign ex_mem_to_reg = ctrl_r.mem_to_reg;
    assign ex_rd         = held_rd_s;
    assign ex_illegal    = ctrl_r.illegal;

    // Decode-side bookkeeping fields are not needed once the word is in EX.
    assign unused_ctrl_s = ^{ctrl_r.is_div, ctrl_r.uses_rs1, ctrl_r.uses_rs2, ctrl_r.rd};

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, ex_flush, ex_ready;
    logic [31:0] id_instr;
    logic        id_ready, ex_valid, ex_branch, ex_mem_read, ex_mem_write;
    logic        ex_alu_src, ex_reg_write, ex_illegal, ex_mdu_busy;
    logic [2:0]  ex_alu_op;
    logic [1:0]  ex_src_a_sel, ex_mem_to_reg;
    logic [4:0]  ex_rd;

    logic        b_id_valid, b_ex_flush, b_ex_ready;
    logic [31:0] b_id_instr;
    logic        b_id_ready, b_ex_valid, b_ex_branch, b_ex_mem_read, b_ex_mem_write;
    logic        b_ex_alu_src, b_ex_reg_write, b_ex_illegal, b_ex_mdu_busy;
    logic [2:0]  b_ex_alu_op;
    logic [1:0]  b_ex_src_a_sel, b_ex_mem_to_reg;
    logic [4:0]  b_ex_rd;

    int checks = 0;
    int errors = 0;
    logic [17:0] qa[$];
    logic [17:0] qb[$];
    logic [17:0] act_a, act_b;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.REG_ADDR_W(5), .ENABLE_M(1'b1), .MDU_LAT(8)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
        .ex_flush(ex_flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_src_a_sel(ex_src_a_sel),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
        .ex_mdu_busy(ex_mdu_busy));

    ctrl_pipe_unit #(.REG_ADDR_W(5), .ENABLE_M(1'b0), .MDU_LAT(8)) dut_b (
        .clk(clk), .rst(rst), .id_valid(b_id_valid), .id_instr(b_id_instr), .id_ready(b_id_ready),
        .ex_flush(b_ex_flush), .ex_ready(b_ex_ready), .ex_valid(b_ex_valid), .ex_branch(b_ex_branch),
        .ex_mem_read(b_ex_mem_read), .ex_mem_write(b_ex_mem_write), .ex_alu_src(b_ex_alu_src),
        .ex_reg_write(b_ex_reg_write), .ex_alu_op(b_ex_alu_op), .ex_src_a_sel(b_ex_src_a_sel),
        .ex_mem_to_reg(b_ex_mem_to_reg), .ex_rd(b_ex_rd), .ex_illegal(b_ex_illegal),
        .ex_mdu_busy(b_ex_mdu_busy));

    assign act_a = {ex_branch, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write,
                    ex_alu_op, ex_src_a_sel, ex_mem_to_reg, ex_rd, ex_illegal};
    assign act_b = {b_ex_branch, b_ex_mem_read, b_ex_mem_write, b_ex_alu_src, b_ex_reg_write,
                    b_ex_alu_op, b_ex_src_a_sel, b_ex_mem_to_reg, b_ex_rd, b_ex_illegal};

    function automatic logic [17:0] cw(input logic br, input logic mr, input logic mw,
                                       input logic as, input logic rw, input logic [2:0] op,
                                       input logic [1:0] sa, input logic [1:0] m2r,
                                       input logic [4:0] rd, input logic ill);
        return {br, mr, mw, as, rw, op, sa, m2r, rd, ill};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: every EX transfer pops and compares one expected word.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL unexpected_a actual=%0h required=none", act_a);
            end else begin
                logic [17:0] e;
                e = qa.pop_front();
                if (act_a !== e) begin
                    errors++;
                    $display("FAIL word_a actual=%0h required=%0h", act_a, e);
                end
            end
        end
        if (!rst && b_ex_valid && b_ex_ready) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_b actual=%0h required=none", act_b);
            end else begin
                logic [17:0] e;
                e = qb.pop_front();
                if (act_b !== e) begin
                    errors++;
                    $display("FAIL word_b actual=%0h required=%0h", act_b, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction, wait (bounded) for acceptance, record its expectation.
    task automatic send(input logic [31:0] ins, input logic [17:0] e);
        int n;
        n = 0;
        id_valid = 1'b1;
        id_instr = ins;
        @(negedge clk);
        while (!id_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", {31'd0, id_ready}, 32'd1);
        if (id_ready) qa.push_back(e);
        step();
        id_valid = 1'b0;
    endtask

    localparam logic [31:0] I_LW5   = {12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] I_ADD6  = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] I_LW0   = {12'd0, 5'd2, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] I_ADD7  = {7'd0, 5'd0, 5'd0, 3'b000, 5'd7, 7'b0110011};
    localparam logic [31:0] I_DIV   = {7'b0000001, 5'd5, 5'd4, 3'b100, 5'd3, 7'b0110011};
    localparam logic [31:0] I_ADDI8 = {12'd5, 5'd0, 3'b000, 5'd8, 7'b0010011};
    localparam logic [31:0] I_ADDI9 = {12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011};
    localparam logic [31:0] I_ADD10 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0110011};
    localparam logic [31:0] I_JAL1  = {20'd0, 5'd1, 7'b1101111};

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; ex_flush = 1'b0; ex_ready = 1'b1;
        b_id_valid = 1'b0; b_id_instr = 32'd0; b_ex_flush = 1'b0; b_ex_ready = 1'b1;
        #2;
        chk("rst_id_ready", {31'd0, id_ready}, 32'd0);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_word", {14'd0, act_a}, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_id_ready", {31'd0, id_ready}, 32'd1);
        step();

        // Load-use: LW x5 then ADD x6,x5,x1.
        id_valid = 1'b1; id_instr = I_LW5;
        qa.push_back(cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 2'b00, 2'b01, 5'd5, 1'b0));
        @(negedge clk);
        chk("lw_accept", {31'd0, id_ready}, 32'd1);
        step();
        id_instr = I_ADD6;
        qa.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 5'd6, 1'b0));
        @(negedge clk);
        chk("lw_valid_c1", {31'd0, ex_valid}, 32'd1);
        chk("hazard_c1", {31'd0, id_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("bubble_c2", {31'd0, ex_valid}, 32'd0);
        chk("add_accept_c2", {31'd0, id_ready}, 32'd1);
        step();
        id_valid = 1'b0;
        @(negedge clk);
        chk("add_valid_c3", {31'd0, ex_valid}, 32'd1);
        step();

        // LW x0 followed by a reader of x0: no stall.
        id_valid = 1'b1; id_instr = I_LW0;
        qa.push_back(cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 2'b01, 5'd0, 1'b0));
        @(negedge clk);
        step();
        id_instr = I_ADD7;
        qa.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 5'd7, 1'b0));
        @(negedge clk);
        chk("x0_no_stall", {31'd0, id_ready}, 32'd1);
        step();
        id_valid = 1'b0;

        // Remaining decode rows through the scoreboard.
        send({7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011},
             cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 5'd0, 1'b0));
        send({7'd0, 5'd3, 5'd2, 3'b010, 5'd0, 7'b0100011},
             cw(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0, 1'b0));
        send({20'h12345, 5'd11, 7'b0110111},
             cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 2'b01, 2'b00, 5'd11, 1'b0));
        send({20'h00001, 5'd12, 7'b0010111},
             cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 2'b11, 2'b00, 5'd12, 1'b0));
        send({12'd0, 5'd1, 3'b000, 5'd13, 7'b1100111},
             cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 2'b00, 2'b11, 5'd13, 1'b0));
        send(32'h0FF0000F, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0, 1'b0));
        send(32'h00000073, cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 2'b00, 2'b00, 5'd0, 1'b0));
        send({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd14, 7'b0110011},
             cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 2'b00, 2'b00, 5'd14, 1'b0));
        @(negedge clk);
        chk("mul_no_stall", {31'd0, ex_valid}, 32'd1);
        step();
        send(32'hFFFFFFFF, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0, 1'b1));
        step();

        // DIV occupies EX for 8 cycles; a following ADDI waits and then streams.
        id_valid = 1'b1; id_instr = I_DIV;
        qa.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 2'b00, 2'b00, 5'd3, 1'b0));
        @(negedge clk);
        chk("div_accept", {31'd0, id_ready}, 32'd1);
        step();
        id_instr = I_ADDI8;
        qa.push_back(cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 2'b00, 2'b00, 5'd8, 1'b0));
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk($sformatf("div_busy_c%0d", c), {29'd0, ex_mdu_busy, ex_valid, id_ready}, 32'd4);
            step();
        end
        @(negedge clk);
        chk("div_valid_c8", {29'd0, ex_mdu_busy, ex_valid, id_ready}, 32'd3);
        step();
        id_valid = 1'b0;
        step();

        // Reset in the middle of a divide (cnt=5).
        id_valid = 1'b1; id_instr = I_DIV;
        @(negedge clk);
        step();
        id_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("busy_before_rst", {31'd0, ex_mdu_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, ex_mdu_busy}, 32'd0);
        chk("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, id_ready}, 32'd0);
        chk("rst_mid_word", {14'd0, act_a}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", {31'd0, id_ready}, 32'd1);
        chk("rst_rel_valid", {31'd0, ex_valid}, 32'd0);
        step();
        @(negedge clk);
        chk("rst_discard", {30'd0, ex_valid, ex_mdu_busy}, 32'd0);
        step();

        // Flush while stalled by back-pressure with a new instruction in ID.
        ex_ready = 1'b0;
        id_valid = 1'b1; id_instr = I_ADDI9;
        @(negedge clk);
        step();
        id_instr = I_ADD10;
        @(negedge clk);
        chk("pre_flush_valid", {31'd0, ex_valid}, 32'd1);
        ex_flush = 1'b1;
        #1;
        chk("flush_id_ready", {31'd0, id_ready}, 32'd0);
        step();
        ex_flush = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("flush_kill", {31'd0, ex_valid}, 32'd0);
        step();

        // JAL x1 held under 20 cycles of back-pressure.
        send(I_JAL1, cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'b01, 2'b11, 5'd1, 1'b0));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("hold_c%0d", c), {13'd0, ex_valid, act_a},
                {13'd0, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 2'b01, 2'b11, 5'd1, 1'b0)});
            step();
        end
        ex_ready = 1'b1;
        step();

        // DIV on the ENABLE_M=0 instance: illegal and no stall.
        b_id_valid = 1'b1; b_id_instr = I_DIV;
        @(negedge clk);
        chk("b_accept", {31'd0, b_id_ready}, 32'd1);
        qb.push_back(cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 5'd0, 1'b1));
        step();
        b_id_valid = 1'b0;
        @(negedge clk);
        chk("b_no_stall", {30'd0, b_ex_valid, b_ex_mdu_busy}, 32'd2);
        step();
        step();

        chk("qa_empty", qa.size(), 32'd0);
        chk("qb_empty", qb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
